chip7458_arbiter: RTL and testbench

Shares one 7458 dual AND-OR gate datapath between two requesters. It arbitrates round-robin, drives the chip inputs, holds them for a programmable settle time, samples p1y/p2y and returns the result to the requester that was granted. It sits between the requester logic and the combinational 7458 block (p1y = (p1a&p1b&p1c)|(p1d&p1e&p1f), p2y = (p2a&p2b)|(p2c&p2d)). Only one transaction is in flight at a time.

---
 rtl/chip7458_arbiter.sv | 142 ++++++++++++++
 tb/tb_chip7458_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip7458_arbiter.sv
// chip7458_arbiter: round-robin sharing of one 7458 dual AND-OR datapath between
// two requesters. Drives the chip inputs, holds them SETTLE cycles, samples
// {p1y,p2y} and returns the result to the granted requester as a one-cycle pulse.
module chip7458_arbiter #(
    parameter int unsigned SETTLE = 2  // legal range 1..15
) (
    input  logic       clk,
    input  logic       areset,
    // requester 0
    input  logic       req0_valid,
    input  logic [9:0] req0_data,
    output logic       req0_ready,
    output logic       rsp0_valid,
    output logic [1:0] rsp0_data,
    // requester 1
    input  logic       req1_valid,
    input  logic [9:0] req1_data,
    output logic       req1_ready,
    output logic       rsp1_valid,
    output logic [1:0] rsp1_data,
    // 7458 datapath
    output logic [5:0] chip_p1,
    output logic [3:0] chip_p2,
    input  logic       chip_p1y,
    input  logic       chip_p2y,
    // status
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StResp  = 2'd2
    } state_e;

    // Counter is reloaded with SETTLE-1 so DRIVE spans exactly SETTLE cycles.
    localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

    state_e     r_state,      w_state_d;
    logic       r_last_grant, w_last_grant_d;  // 0: requester 0 served last
    logic       r_grant,      w_grant_d;       // requester of the in-flight transaction
    logic [3:0] r_settle_cnt, w_settle_cnt_d;
    logic [5:0] r_chip_p1,    w_chip_p1_d;
    logic [3:0] r_chip_p2,    w_chip_p2_d;
    logic [1:0] r_rsp0_data,  w_rsp0_data_d;
    logic [1:0] r_rsp1_data,  w_rsp1_data_d;

    logic       w_idle;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_accept;
    logic [9:0] w_sel_data;

    // Round-robin grant: a lone requester always wins, a tie goes to the one not served last.
    always_comb begin
        w_idle     = (r_state == StIdle);
        w_grant0   = req0_valid & (~req1_valid | r_last_grant);
        w_grant1   = req1_valid & (~req0_valid | ~r_last_grant);
        w_accept   = w_idle & (w_grant0 | w_grant1);
        w_sel_data = w_grant1 ? req1_data : req0_data;
    end

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        w_state_d      = r_state;
        w_last_grant_d = r_last_grant;
        w_grant_d      = r_grant;
        w_settle_cnt_d = r_settle_cnt;
        w_chip_p1_d    = r_chip_p1;
        w_chip_p2_d    = r_chip_p2;
        w_rsp0_data_d  = r_rsp0_data;
        w_rsp1_data_d  = r_rsp1_data;

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d      = StDrive;
                    w_chip_p1_d    = w_sel_data[9:4];
                    w_chip_p2_d    = w_sel_data[3:0];
                    w_grant_d      = w_grant1;
                    w_last_grant_d = w_grant1;
                    w_settle_cnt_d = SettleLoad;
                end
            end
            StDrive: begin
                if (r_settle_cnt == 4'd0) begin
                    w_state_d = StResp;
                    if (r_grant) begin
                        w_rsp1_data_d = {chip_p1y, chip_p2y};
                    end else begin
                        w_rsp0_data_d = {chip_p1y, chip_p2y};
                    end
                end else begin
                    w_settle_cnt_d = r_settle_cnt - 4'd1;
                end
            end
            StResp: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State register; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_settle_cnt <= 4'd0;
            r_chip_p1    <= 6'd0;
            r_chip_p2    <= 4'd0;
            r_rsp0_data  <= 2'd0;
            r_rsp1_data  <= 2'd0;
        end else begin
            r_state      <= w_state_d;
            r_last_grant <= w_last_grant_d;
            r_grant      <= w_grant_d;
            r_settle_cnt <= w_settle_cnt_d;
            r_chip_p1    <= w_chip_p1_d;
            r_chip_p2    <= w_chip_p2_d;
            r_rsp0_data  <= w_rsp0_data_d;
            r_rsp1_data  <= w_rsp1_data_d;
        end
    end

    // Output decode; ready is combinational on the request valids.
    always_comb begin
        req0_ready = w_idle & w_grant0;
        req1_ready = w_idle & w_grant1;
        rsp0_valid = (r_state == StResp) & ~r_grant;
        rsp1_valid = (r_state == StResp) & r_grant;
        rsp0_data  = r_rsp0_data;
        rsp1_data  = r_rsp1_data;
        chip_p1    = r_chip_p1;
        chip_p2    = r_chip_p2;
        busy       = ~w_idle;
    end

endmodule

// File: tb/tb_chip7458_arbiter.sv
// Directed bench for chip7458_arbiter: one instance with SETTLE=2 and one with SETTLE=1,
// each feeding a behavioural 7458 model back into the sample inputs.
module tb_chip7458_arbiter;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    // SETTLE=2 instance
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [9:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [1:0] rsp0_data, rsp1_data;
    logic [5:0] chip_p1;
    logic [3:0] chip_p2;
    logic       chip_p1y, chip_p2y;

    // SETTLE=1 instance
    logic       s1_req0_valid = 1'b0, s1_req1_valid = 1'b0;
    logic [9:0] s1_req0_data = '0, s1_req1_data = '0;
    logic       s1_req0_ready, s1_req1_ready, s1_rsp0_valid, s1_rsp1_valid, s1_busy;
    logic [1:0] s1_rsp0_data, s1_rsp1_data;
    logic [5:0] s1_chip_p1;
    logic [3:0] s1_chip_p2;
    logic       s1_chip_p1y, s1_chip_p2y;

    // 7458 models
    assign chip_p1y = (chip_p1[5] & chip_p1[4] & chip_p1[3]) | (chip_p1[2] & chip_p1[1] & chip_p1[0]);
    assign chip_p2y = (chip_p2[3] & chip_p2[2]) | (chip_p2[1] & chip_p2[0]);
    assign s1_chip_p1y = (s1_chip_p1[5] & s1_chip_p1[4] & s1_chip_p1[3]) |
                         (s1_chip_p1[2] & s1_chip_p1[1] & s1_chip_p1[0]);
    assign s1_chip_p2y = (s1_chip_p2[3] & s1_chip_p2[2]) | (s1_chip_p2[1] & s1_chip_p2[0]);

    chip7458_arbiter #(.SETTLE(2)) u_dut (
        .clk(clk), .areset(areset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .chip_p1(chip_p1), .chip_p2(chip_p2), .chip_p1y(chip_p1y), .chip_p2y(chip_p2y),
        .busy(busy)
    );

    chip7458_arbiter #(.SETTLE(1)) u_dut_s1 (
        .clk(clk), .areset(areset),
        .req0_valid(s1_req0_valid), .req0_data(s1_req0_data), .req0_ready(s1_req0_ready),
        .rsp0_valid(s1_rsp0_valid), .rsp0_data(s1_rsp0_data),
        .req1_valid(s1_req1_valid), .req1_data(s1_req1_data), .req1_ready(s1_req1_ready),
        .rsp1_valid(s1_rsp1_valid), .rsp1_data(s1_rsp1_data),
        .chip_p1(s1_chip_p1), .chip_p2(s1_chip_p2), .chip_p1y(s1_chip_p1y),
        .chip_p2y(s1_chip_p2y), .busy(s1_busy)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref7458(input logic [9:0] d);
        logic p1y, p2y;
        p1y = (d[9] & d[8] & d[7]) | (d[6] & d[5] & d[4]);
        p2y = (d[3] & d[2]) | (d[1] & d[0]);
        return {p1y, p2y};
    endfunction

    initial begin
        int k;
        int accepted;
        int responses;
        logic [9:0] op;

        // ---------------- reset then idle ----------------
        tick(); tick();
        areset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(); #1;
            chk("idle_busy", busy, 0);
            chk("idle_ready0", req0_ready, 0);
            chk("idle_ready1", req1_ready, 0);
            chk("idle_rspv", {rsp0_valid, rsp1_valid}, 0);
            chk("idle_rspd", {rsp0_data, rsp1_data}, 0);
            chk("idle_chip", {chip_p1, chip_p2}, 0);
        end

        // ---------------- single req0, SETTLE=2 ----------------
        tick();
        req0_valid = 1'b1; req0_data = 10'b111000_1100; #1;    // cycle T
        chk("s_ready0_T", req0_ready, 1);
        chk("s_ready1_T", req1_ready, 0);
        tick(); req0_valid = 1'b0; #1;                          // T+1
        chk("s_chip_p1", chip_p1, 6'b111000);
        chk("s_chip_p2", chip_p2, 4'b1100);
        chk("s_busy_T1", busy, 1);
        chk("s_rspv_T1", rsp0_valid, 0);
        tick(); #1;                                             // T+2
        chk("s_rspv_T2", rsp0_valid, 0);
        chk("s_chip_T2", {chip_p1, chip_p2}, 10'b111000_1100);
        tick(); #1;                                             // T+3
        chk("s_rspv_T3", rsp0_valid, 1);
        chk("s_rspd_T3", rsp0_data, 2'b11);
        chk("s_rsp1v_T3", rsp1_valid, 0);
        tick(); #1;                                             // T+4
        chk("s_rspv_T4", rsp0_valid, 0);
        chk("s_busy_T4", busy, 0);
        chk("s_rspd_hold", rsp0_data, 2'b11);
        chk("s_rsp1d", rsp1_data, 2'b00);
        chk("s_chip_hold", {chip_p1, chip_p2}, 10'b111000_1100);

        // ---------------- tie between requesters ----------------
        areset = 1'b1; tick(); areset = 1'b0;
        tick();
        req0_valid = 1'b1; req0_data = 10'b000111_0011;
        req1_valid = 1'b1; req1_data = 10'b110110_1010; #1;    // T
        chk("t_ready0_T", req0_ready, 1);
        chk("t_ready1_T", req1_ready, 0);
        tick(); req0_valid = 1'b0; #1;                          // T+1
        chk("t_ready1_T1", req1_ready, 0);
        tick(); #1;                                             // T+2
        chk("t_ready1_T2", req1_ready, 0);
        tick(); #1;                                             // T+3
        chk("t_rsp0v_T3", rsp0_valid, 1);
        chk("t_rsp0d_T3", rsp0_data, 2'b11);
        chk("t_ready1_T3", req1_ready, 0);
        tick(); #1;                                             // T+4 idle
        chk("t_ready1_T4", req1_ready, 1);
        chk("t_rsp0v_T4", rsp0_valid, 0);
        tick(); req1_valid = 1'b0; #1;                          // T+5
        chk("t_chip_T5", {chip_p1, chip_p2}, 10'b110110_1010);
        tick(); tick(); #1;                                     // T+7
        chk("t_rsp1v_T7", rsp1_valid, 1);
        chk("t_rsp1d_T7", rsp1_data, 2'b00);
        chk("t_rsp0d_keep", rsp0_data, 2'b11);
        chk("t_rsp0v_T7", rsp0_valid, 0);
        tick();                                                 // T+8 idle, new tie
        req0_valid = 1'b1; req0_data = 10'b000000_0000;
        req1_valid = 1'b1; req1_data = 10'b111111_1111; #1;
        chk("t2_ready0", req0_ready, 1);
        chk("t2_ready1", req1_ready, 0);
        tick(); req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick(); #1;                                     // T+11
        chk("t2_rsp0v", rsp0_valid, 1);
        chk("t2_rsp0d", rsp0_data, 2'b00);
        chk("t2_rsp1d_keep", rsp1_data, 2'b00);
        tick();

        // ---------------- sweep all operands through req1 ----------------
        accepted = 0;
        responses = 0;
        for (int i = 0; i < 1024; i++) begin
            op = 10'(i);
            req1_valid = 1'b1; req1_data = op; #1;
            chk("sw_ready", req1_ready, 1);
            if (req1_ready) accepted++;
            tick(); req1_valid = 1'b0;
            k = 0;
            while (k < 6) begin
                #1;
                if (rsp1_valid) break;
                tick();
                k++;
            end
            chk("sw_lat", k, 2);
            if (k < 6) begin
                responses++;
                chk("sw_data", rsp1_data, ref7458(op));
                chk("sw_rsp0v", rsp0_valid, 0);
            end
            tick(); #1;
            chk("sw_single", rsp1_valid, 0);
        end
        chk("sw_count", responses, accepted);
        chk("sw_accepted", accepted, 1024);

        // ---------------- areset during DRIVE ----------------
        tick();
        req0_valid = 1'b1; req0_data = 10'b111111_1111; #1;
        chk("r_ready0", req0_ready, 1);
        tick(); req0_valid = 1'b0; #1;                          // DRIVE
        chk("r_busy_drive", busy, 1);
        areset = 1'b1; #1;
        chk("r_busy_async", busy, 0);
        chk("r_chip_async", {chip_p1, chip_p2}, 0);
        tick(); areset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(); #1;
            chk("r_no_rsp", {rsp0_valid, rsp1_valid}, 0);
            chk("r_rsp0d", rsp0_data, 0);
        end
        req0_valid = 1'b1; req0_data = 10'b111000_1100; #1;
        chk("r2_ready0", req0_ready, 1);
        tick(); req0_valid = 1'b0;
        tick(); tick(); #1;
        chk("r2_rspv", rsp0_valid, 1);
        chk("r2_rspd", rsp0_data, 2'b11);

        // ---------------- SETTLE=1 back-to-back req0 ----------------
        tick();
        s1_req0_valid = 1'b1; s1_req0_data = 10'b111000_1100;
        for (int c = 0; c < 9; c++) begin
            #1;
            chk("s1_ready", s1_req0_ready, (c % 3) == 0);
            chk("s1_rspv", s1_rsp0_valid, (c % 3) == 2);
            if ((c % 3) == 2) chk("s1_rspd", s1_rsp0_data, 2'b11);
            tick();
        end
        s1_req0_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
